// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and flush controller for a 5-stage RISC-V pipeline.
// Keeps a shadow scoreboard of the EX/MEM/WB occupants and derives the PC and
// IF/ID enables, flush/bubble controls and the EX operand-forwarding selects.
// Stage suffixes: _p0 = EX slot, _p1 = MEM slot, _p2 = WB slot.
module pipe_hazard_ctrl #(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              ex_branch_taken,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Saturating increment for the performance counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Forwarding source for one EX operand; a load in MEM has no data yet and
  // never forwards, and x0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(
    input logic              ex_vld,
    input logic              use_rs,
    input logic [REG_AW-1:0] rs,
    input logic              mem_vld,
    input logic              mem_rw,
    input logic              mem_ld,
    input logic [REG_AW-1:0] mem_rd,
    input logic              wb_vld,
    input logic              wb_rw,
    input logic [REG_AW-1:0] wb_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_vld && use_rs) begin
      if (mem_vld && mem_rw && !mem_ld && (mem_rd != '0) && (mem_rd == rs))
        sel = FWD_MEM;
      else if (wb_vld && wb_rw && (wb_rd != '0) && (wb_rd == rs))
        sel = FWD_WB;
    end
    return sel;
  endfunction

  // EX slot (p0)
  logic              r_vld_p0, r_rw_p0, r_ld_p0, r_u1_p0, r_u2_p0;
  logic [REG_AW-1:0] r_rd_p0, r_rs1_p0, r_rs2_p0;
  // MEM slot (p1)
  logic              r_vld_p1, r_rw_p1, r_ld_p1;
  logic [REG_AW-1:0] r_rd_p1;
  // WB slot (p2)
  logic              r_vld_p2, r_rw_p2;
  logic [REG_AW-1:0] r_rd_p2;

  logic w_mem_wait, w_flush, w_load_use, w_stall;
  logic w_pc_en, w_ifid_en, w_ifid_flush, w_idex_bubble;

  // Hazard classification in priority order: memory wait, flush, load-use, run.
  always_comb begin
    w_mem_wait = r_vld_p1 && !mem_ready;
    w_flush    = !w_mem_wait && ex_branch_taken;
    w_load_use = !w_mem_wait && !ex_branch_taken &&
                 r_vld_p0 && r_ld_p0 && r_rw_p0 && (r_rd_p0 != '0) && id_valid &&
                 ((id_use_rs1 && (id_rs1 == r_rd_p0)) ||
                  (id_use_rs2 && (id_rs2 == r_rd_p0)));
    w_stall       = w_mem_wait || w_load_use;
    w_pc_en       = !w_stall;
    w_ifid_en     = !w_stall;
    w_ifid_flush  = w_flush;
    w_idex_bubble = w_flush || w_load_use;
  end

  // Control outputs are held low for as long as reset is asserted.
  always_comb begin
    pc_en       = reset_n && w_pc_en;
    ifid_en     = reset_n && w_ifid_en;
    ifid_flush  = reset_n && w_ifid_flush;
    idex_bubble = reset_n && w_idex_bubble;
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    if (reset_n) begin
      fwd_a = fwd_sel(r_vld_p0, r_u1_p0, r_rs1_p0, r_vld_p1, r_rw_p1, r_ld_p1,
                      r_rd_p1, r_vld_p2, r_rw_p2, r_rd_p2);
      fwd_b = fwd_sel(r_vld_p0, r_u2_p0, r_rs2_p0, r_vld_p1, r_rw_p1, r_ld_p1,
                      r_rd_p1, r_vld_p2, r_rw_p2, r_rd_p2);
    end
  end

  // Slot valid bits: the whole scoreboard freezes while memory is waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else if (!w_mem_wait) begin
      r_vld_p2 <= r_vld_p1;
      r_vld_p1 <= r_vld_p0;
      r_vld_p0 <= id_valid && !w_idex_bubble;
    end
  end

  // Slot payload fields: only meaningful when the slot's valid bit is set,
  // so they need no reset.
  always_ff @(posedge clk) begin
    if (!w_mem_wait) begin
      r_rd_p2  <= r_rd_p1;
      r_rw_p2  <= r_rw_p1;
      r_rd_p1  <= r_rd_p0;
      r_rw_p1  <= r_rw_p0;
      r_ld_p1  <= r_ld_p0;
      r_rd_p0  <= id_rd;
      r_rw_p0  <= id_reg_write;
      r_ld_p0  <= id_is_load;
      r_rs1_p0 <= id_rs1;
      r_rs2_p0 <= id_rs2;
      r_u1_p0  <= id_use_rs1;
      r_u2_p0  <= id_use_rs2;
    end
  end

  // Performance counters: stall cycles (pc_en low) and flush events.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (w_stall) stall_cnt <= sat_inc(stall_cnt);
      if (w_flush) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl. Inputs change just after the
// falling edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_pipe_hazard_ctrl;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              ex_branch_taken, mem_ready;

  logic        pc_en, ifid_en, ifid_flush, idex_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_bubble;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16), .REG_AW(REG_AW)) u_dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  pipe_hazard_ctrl #(.CNT_W(2), .REG_AW(REG_AW)) u_sat (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
    .idex_bubble(s_idex_bubble), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic pc, input logic ifid,
                          input logic fl, input logic bub);
    chk({tag, ".pc_en"}, 32'(pc_en), 32'(pc));
    chk({tag, ".ifid_en"}, 32'(ifid_en), 32'(ifid));
    chk({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(fl));
    chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bub));
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
    chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(a));
    chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(b));
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0; id_rd = '0; id_reg_write = 1'b0; id_is_load = 1'b0;
    ex_branch_taken = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic rw,
                       input logic ld);
    id_valid = 1'b1; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_is_load = ld;
  endtask

  // Advance to the next sampling point: one rising edge has passed.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic randomize_inputs();
    id_valid = 1'($urandom_range(1, 0)); id_rs1 = 5'($urandom_range(31, 0));
    id_rs2 = 5'($urandom_range(31, 0)); id_use_rs1 = 1'($urandom_range(1, 0));
    id_use_rs2 = 1'($urandom_range(1, 0)); id_rd = 5'($urandom_range(31, 0));
    id_reg_write = 1'($urandom_range(1, 0)); id_is_load = 1'($urandom_range(1, 0));
    ex_branch_taken = 1'($urandom_range(1, 0)); mem_ready = 1'($urandom_range(1, 0));
  endtask

  task automatic drain();
    idle();
    repeat (3) cyc();
  endtask

  initial begin
    // ---------------- reset with random inputs
    reset_n = 1'b0;
    idle();
    repeat (2) begin
      cyc(); randomize_inputs(); #1;
      chk_ctrl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk_fwd("rst", 2'b00, 2'b00);
      chk("rst.stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst.flush_cnt", 32'(flush_cnt), 32'd0);
    end
    cyc(); idle(); reset_n = 1'b1; #1;
    chk_ctrl("rel", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_fwd("rel", 2'b00, 2'b00);

    // ---------------- ALU chain: add x5; sub x6,x5,x1 -> EX/MEM forward
    cyc(); instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0); #1;
    chk_ctrl("alu1", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(); instr(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0); #1;
    chk_ctrl("alu2", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_fwd("alu2", 2'b00, 2'b00);
    cyc(); idle(); #1;
    chk_fwd("alu3", 2'b01, 2'b00);

    // ---------------- add x5; or x11,x3,x4; sub x6,x5,x11 -> A from WB, B from MEM
    drain();
    instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    cyc(); instr(5'd3, 1'b1, 5'd4, 1'b1, 5'd11, 1'b1, 1'b0);
    cyc(); instr(5'd5, 1'b1, 5'd11, 1'b1, 5'd6, 1'b1, 1'b0);
    cyc(); idle(); #1;
    chk_fwd("gap", 2'b10, 2'b01);

    // ---------------- add x5; add x5; sub x6,x5,x0 -> MEM beats WB, x0 never forwards
    drain();
    instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    cyc(); instr(5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0);
    cyc(); instr(5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
    cyc(); idle(); #1;
    chk_fwd("prio", 2'b01, 2'b00);

    // ---------------- load-use: lw x7; add x8,x7,x2
    drain();
    instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); #1;
    chk_ctrl("lu0", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(); instr(5'd7, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0); #1;
    chk_ctrl("lu1", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(); #1;
    chk_ctrl("lu2", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lu2.stall_cnt", 32'(stall_cnt), 32'd1);
    cyc(); idle(); #1;
    chk_fwd("lu3", 2'b10, 2'b00);
    chk("lu3.stall_cnt", 32'(stall_cnt), 32'd1);

    // ---------------- branch flush: the x13 reader squashed in ID must not reach EX
    drain();
    instr(5'd1, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0);
    cyc(); instr(5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0); ex_branch_taken = 1'b1; #1;
    chk_ctrl("br0", 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(); idle(); #1;
    chk_fwd("br1", 2'b00, 2'b00);
    chk_ctrl("br1", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("br1.flush_cnt", 32'(flush_cnt), 32'd1);

    // ---------------- memory wait with a branch re-presented by the frozen EX
    cyc(); idle(); reset_n = 1'b0; #1;
    chk("rst2.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst2.flush_cnt", 32'(flush_cnt), 32'd0);
    cyc(); reset_n = 1'b1;
    instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1);
    cyc(); instr(5'd3, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0);
    cyc(); instr(5'd15, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0); mem_ready = 1'b0; #1;
    chk_ctrl("mw0", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); ex_branch_taken = 1'b1; #1;
    chk_ctrl("mw1", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); #1;
    chk_ctrl("mw2", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mw2.flush_cnt", 32'(flush_cnt), 32'd0);
    cyc(); mem_ready = 1'b1; #1;
    chk_ctrl("mw3", 1'b1, 1'b1, 1'b1, 1'b1);
    chk("mw3.stall_cnt", 32'(stall_cnt), 32'd3);
    cyc(); idle(); #1;
    chk("mw4.stall_cnt", 32'(stall_cnt), 32'd3);
    chk("mw4.flush_cnt", 32'(flush_cnt), 32'd1);
    chk_ctrl("mw4", 1'b1, 1'b1, 1'b0, 1'b0);

    // ---------------- x0 load then reader of x0: no stall, no forward
    drain();
    instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    cyc(); instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd17, 1'b1, 1'b0); #1;
    chk_ctrl("x0a", 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(); idle(); #1;
    chk_fwd("x0b", 2'b00, 2'b00);
    cyc(); #1;
    chk_fwd("x0c", 2'b00, 2'b00);

    // ---------------- saturation: 5 stall cycles on a 2-bit counter
    cyc(); idle(); reset_n = 1'b0;
    cyc(); reset_n = 1'b1;
    instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 1'b1);
    cyc(); idle();
    cyc(); mem_ready = 1'b0;
    repeat (5) cyc();
    idle(); #1;
    chk("sat.s_stall_cnt", 32'(s_stall_cnt), 32'd3);
    chk("sat.stall_cnt", 32'(stall_cnt), 32'd5);

    // ---------------- reset in the middle of a load-use stall
    drain();
    instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    cyc(); instr(5'd7, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0); #1;
    chk_ctrl("rms0", 1'b0, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b0; #1;
    chk_ctrl("rms1", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rms1.stall_cnt", 32'(stall_cnt), 32'd0);
    cyc(); reset_n = 1'b1; #1;
    chk_ctrl("rms2", 1'b1, 1'b1, 1'b0, 1'b0);
    chk_fwd("rms2", 2'b00, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
